// File: rtl/llr_phase_ctrl_pkg.sv
// Shared encodings for the llr_former phase-ambiguity search controller.
package llr_phase_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  localparam int unsigned PHASE_IDX_WIDTH = 3;

endpackage

// File: rtl/sym_window_cnt.sv
// Symbol window counter: counts enabled symbols and pulses when the terminal value is reached,
// restarting from zero so the next window begins on the following symbol.
module sym_window_cnt #(
  parameter int unsigned Width = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             count_i,
  input  logic [Width-1:0] term_i,
  output logic             term_o
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             hit;

  assign hit = count_i && (cnt_q == term_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (hit) begin
      cnt_d = '0;
    end else if (count_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = hit;

endmodule

// File: rtl/llr_phase_ctrl.sv
// Phase-ambiguity search controller: steps llr_former's phase until the decoder reports frame
// sync, then supervises sync and restarts the search after too many sync-less windows.
module llr_phase_ctrl
  import llr_phase_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_WIDTH = 24,
  parameter int unsigned LOSS_WIDTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned SWEEP_WIDTH   = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic [TIMEOUT_WIDTH-1:0]   i_window,
  input  logic [LOSS_WIDTH-1:0]      i_loss_thr,
  input  logic                       i_valid,
  input  logic                       i_sync,
  input  logic                       i_last_phase_stb,
  output logic                       o_shift_phase_stb,
  output logic                       o_locked,
  output logic [PHASE_IDX_WIDTH-1:0] o_phase_idx,
  output logic [SWEEP_WIDTH-1:0]     o_sweep_cnt,
  output logic [1:0]                 o_state
);

  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);

  state_e                     state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0]   term_q, term_d;
  logic [LOSS_WIDTH-1:0]      thr_q, thr_d;
  logic [LOSS_WIDTH-1:0]      loss_q, loss_d;
  logic [SettleW-1:0]         settle_q, settle_d;
  logic [PHASE_IDX_WIDTH-1:0] phase_q, phase_d;
  logic [SWEEP_WIDTH-1:0]     sweep_q, sweep_d;
  logic                       stb_q, stb_d;
  logic                       locked_q, locked_d;

  logic                       counting;
  logic                       win_clear;
  logic                       win_count;
  logic                       expire;
  logic                       enter_shift;
  logic [LOSS_WIDTH-1:0]      loss_inc;

  assign counting  = (state_q == ST_SEARCH) || (state_q == ST_LOCKED);
  // Sync restarts the window; the counter idles at zero outside SEARCH/LOCKED.
  assign win_clear = !counting || i_sync;
  assign win_count = counting && i_valid;
  assign loss_inc  = (&loss_q) ? loss_q : loss_q + LOSS_WIDTH'(1);

  sym_window_cnt #(
    .Width (TIMEOUT_WIDTH)
  ) u_sym_window_cnt (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .clear_i (win_clear),
    .count_i (win_count),
    .term_i  (term_q),
    .term_o  (expire)
  );

  always_comb begin
    state_d     = state_q;
    term_d      = term_q;
    thr_d       = thr_q;
    loss_d      = loss_q;
    settle_d    = settle_q;
    phase_d     = phase_q;
    sweep_d     = sweep_q;
    enter_shift = 1'b0;

    if (!i_enable) begin
      state_d  = ST_IDLE;
      loss_d   = '0;
      settle_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d  = ST_SEARCH;
          term_d   = (i_window == '0) ? '0 : i_window - TIMEOUT_WIDTH'(1);
          thr_d    = (i_loss_thr == '0) ? LOSS_WIDTH'(1) : i_loss_thr;
          loss_d   = '0;
          settle_d = '0;
        end
        ST_SEARCH: begin
          if (i_sync) begin
            state_d = ST_LOCKED;
            loss_d  = '0;
          end else if (expire) begin
            enter_shift = 1'b1;
          end
        end
        ST_SHIFT: begin
          if (settle_q == SettleLast) begin
            state_d  = ST_SEARCH;
            settle_d = '0;
          end else begin
            settle_d = settle_q + SettleW'(1);
          end
        end
        ST_LOCKED: begin
          if (i_sync) begin
            loss_d = '0;
          end else if (expire) begin
            if (loss_inc >= thr_q) begin
              enter_shift = 1'b1;
            end else begin
              loss_d = loss_inc;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (enter_shift) begin
      state_d  = ST_SHIFT;
      settle_d = '0;
      loss_d   = '0;
      phase_d  = phase_q + PHASE_IDX_WIDTH'(1);
    end

    // The former's wrap indication overrides a coincident shift increment.
    if (i_last_phase_stb) begin
      phase_d = '0;
      sweep_d = (&sweep_q) ? sweep_q : sweep_q + SWEEP_WIDTH'(1);
    end

    stb_d    = enter_shift;
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      term_q   <= '0;
      thr_q    <= '0;
      loss_q   <= '0;
      settle_q <= '0;
      phase_q  <= '0;
      sweep_q  <= '0;
      stb_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      term_q   <= term_d;
      thr_q    <= thr_d;
      loss_q   <= loss_d;
      settle_q <= settle_d;
      phase_q  <= phase_d;
      sweep_q  <= sweep_d;
      stb_q    <= stb_d;
      locked_q <= locked_d;
    end
  end

  assign o_shift_phase_stb = stb_q;
  assign o_locked          = locked_q;
  assign o_phase_idx       = phase_q;
  assign o_sweep_cnt       = sweep_q;
  assign o_state           = state_q;

endmodule

// File: doc/llr_phase_ctrl.md
# llr_phase_ctrl

Phase-ambiguity search controller for `llr_former` running with `AUTO_PHASE_CTRL = 0`. It counts input symbols while the downstream decoder tries to acquire frame sync. If sync does not arrive within a programmable window, it pulses the former's phase-shift strobe. Once locked, it supervises sync and re-enters the search after a programmable number of missed windows. It sits beside `llr_former`: it drives `i_shift_phase_stb` and consumes `o_last_phase_stb`, the former's symbol valid, and the decoder's sync.

## Interface
- `TIMEOUT_WIDTH`, 24, width of the symbol window count.
- `LOSS_WIDTH`, 4, width of the loss threshold and loss counter.
- `SETTLE_CYCLES`, 16, cycles spent in SHIFT (strobe plus former pipeline flush); must be ≥ 2.
- `SWEEP_WIDTH`, 8, width of the completed-sweep counter.
- `i_clk`  in  1  single clock, shared with `llr_former`.
- `i_reset`  in  1  reset, synchronous, active-high.
- `i_enable`  in  1  run control; low forces IDLE.
- `i_window`  in  TIMEOUT_WIDTH  symbols per search/supervision window; 0 is treated as 1.
- `i_loss_thr`  in  LOSS_WIDTH  consecutive sync-less windows in LOCKED before re-search; 0 is treated as 1.
- `i_valid`  in  1  symbol strobe, same as the former's `i_valid`.
- `i_sync`  in  1  decoder frame-sync pulse.
- `i_last_phase_stb`  in  1  from the former; the rotation has wrapped to 0.
- `o_shift_phase_stb`  out  1  one-cycle phase-advance pulse to the former.
- `o_locked`  out  1  high in LOCKED.
- `o_phase_idx`  out  3  shifts issued since the current sweep began.
- `o_sweep_cnt`  out  SWEEP_WIDTH  completed sweeps, saturating.
- `o_state`  out  2  IDLE=0, SEARCH=1, SHIFT=2, LOCKED=3.

## Operation
- `i_window` and `i_loss_thr` are sampled on the IDLE→SEARCH transition only. Changes mid-run are ignored.
- **IDLE:** all counters are held at 0. When `i_enable` = 1, go to SEARCH.
- **SEARCH:**
  - `sym_cnt` increments on each `i_valid`.
  - `i_sync` → LOCKED; clear `sym_cnt`, `loss_cnt`.
  - `i_valid` with `sym_cnt == window-1` → SHIFT.
  - If `i_sync` and expiry occur in the same cycle, LOCKED wins.
- **SHIFT:**
  - The first cycle in SHIFT asserts `o_shift_phase_stb` for exactly 1 cycle and increments `o_phase_idx`.
  - `settle_cnt` runs for SETTLE_CYCLES, then the block goes to SEARCH with `sym_cnt` = 0.
  - `i_sync` and `i_valid` are ignored in SHIFT, because they refer to the old phase.
- **LOCKED:**
  - `sym_cnt` counts `i_valid`.
  - `i_sync` clears `sym_cnt` and `loss_cnt`.
  - Window expiry without sync increments `loss_cnt` and clears `sym_cnt`.
  - When `loss_cnt` reaches `loss_thr`, go to SHIFT.
  - `o_locked` is low from the cycle SHIFT is entered.
- **Phase wrap:** `i_last_phase_stb` clears `o_phase_idx` to 0 and increments `o_sweep_cnt`, saturating at all-ones. If a shift increment and `i_last_phase_stb` occur in the same cycle, the clear wins.
- **`i_enable` low** in any state → IDLE next cycle. No strobe is issued afterwards; `o_phase_idx` and `o_sweep_cnt` are retained.
- **`i_reset`:** all outputs and counters are 0 and the state is IDLE. A reset mid-SHIFT aborts the settle and produces no further strobe. The former must be reset together with this block so that its angle restarts at 0, consistent with `o_phase_idx` = 0.

## Timing
- All outputs are registered. Reset values:
  - `o_shift_phase_stb` = 0
  - `o_locked` = 0
  - `o_phase_idx` = 0
  - `o_sweep_cnt` = 0
  - `o_state` = 0
- **Strobe latency:** an expiring `i_valid` in cycle t → `o_state` = SHIFT and `o_shift_phase_stb` = 1 in cycle t+1.
- **Sync latency:** `i_sync` in cycle t → `o_locked` = 1 in cycle t+1.
- **SHIFT duration:** exactly SETTLE_CYCLES cycles; SEARCH is entered at t+1+SETTLE_CYCLES.
- **Strobe spacing:** at least SETTLE_CYCLES+1 cycles between strobes.
- **Wrap timing:** the former returns `o_last_phase_stb` 1 cycle after the strobe; `o_phase_idx` clears 1 cycle after that.
- **Counter widths:** `sym_cnt` is TIMEOUT_WIDTH bits and is compared to `window-1`; it never wraps. `loss_cnt` is LOSS_WIDTH bits and saturates.

## Structure
- Package `llr_phase_ctrl_pkg` holds:
  - the state encoding constants `ST_IDLE`, `ST_SEARCH`, `ST_SHIFT`, `ST_LOCKED`;
  - a `PHASE_IDX_WIDTH` = 3 constant.
- Sub-module `sym_window_cnt`:
  - inputs: clear, count-enable, terminal value;
  - output: a one-cycle terminal pulse.
- `sym_window_cnt` is instantiated once and shared by SEARCH and LOCKED.
- The FSM, settle counter, loss counter, and phase/sweep tracking live in the top level.

## Test plan
- **Window expiry:** `i_window` = 10, no sync, continuous `i_valid`.
  - One strobe follows the 10th valid by 1 cycle; SHIFT lasts 16 cycles.
  - The next strobe follows 10 valids later; `o_phase_idx` steps 1, 2, ….
- **Acquisition:** `i_sync` on the 5th valid of SEARCH.
  - `o_locked` = 1 on the next cycle and no strobe is issued.
  - With `i_sync` every 8 valids and `i_window` = 10, lock is held indefinitely.
- **Loss of lock:** `i_loss_thr` = 3, sync stops in LOCKED.
  - After 30 valids, SHIFT is entered and a strobe is issued; `o_locked` drops on the same cycle.
- **Sweep wrap:** a model former with step 1 returns `o_last_phase_stb` on the 8th strobe.
  - `o_phase_idx` reads 0 and `o_sweep_cnt` = 1.
  - With `SWEEP_WIDTH` = 2, the counter saturates at 3 after 4 sweeps.
- **Boundary:** `i_sync` and the expiring valid in the same cycle go to LOCKED with no strobe. `i_window` = 0 behaves as 1, giving a strobe after every valid.
- **Abort:** `i_reset` in SHIFT cycle 3 gives all outputs 0 next cycle and no strobe. `i_enable` dropped in SHIFT gives IDLE next cycle with `o_phase_idx` retained.
